// File: rtl/d8m_power_sequencer.sv
// d8m_power_sequencer: D8M camera power-up/reset/configure sequencer with retry and fault handling.
module d8m_power_sequencer #(
  parameter int unsigned T_PWDN_CYC = 500000,
  parameter int unsigned T_RST_CYC  = 50000,
  parameter int unsigned T_CFG_TO   = 5000000,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       enable,
  input  logic       cfg_done,
  input  logic       cfg_err,
  output logic       mipi_pwdn_n,
  output logic       mipi_reset_n,
  output logic       xclk_en,
  output logic       cfg_start,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);
  typedef enum logic [2:0] {OFF = 3'd0, PWRUP = 3'd1, RSTREL = 3'd2, CONFIG = 3'd3, RUN = 3'd4, FAULT = 3'd5} state_t;
  if (T_PWDN_CYC > 32'hFF_FFFF || T_RST_CYC > 32'hFF_FFFF || T_CFG_TO > 32'hFF_FFFF) begin : g_bad_time
    $error("d8m_power_sequencer: dwell/timeout parameter exceeds 24-bit counter");
  end
  if (MAX_RETRY < 1 || MAX_RETRY > 3) begin : g_bad_retry
    $error("d8m_power_sequencer: MAX_RETRY must be 1..3");
  end
  localparam logic [23:0] LD_PWDN = (T_PWDN_CYC == 0) ? 24'd0 : 24'(T_PWDN_CYC - 1);
  localparam logic [23:0] LD_RST  = (T_RST_CYC == 0) ? 24'd0 : 24'(T_RST_CYC - 1);
  localparam logic [23:0] LD_CFG  = (T_CFG_TO == 0) ? 24'd0 : 24'(T_CFG_TO - 1);
  localparam logic [1:0]  MAXR    = 2'(MAX_RETRY);
  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [1:0]  retry_q, retry_d, retry_inc;
  logic        live, done, fail;
  // cfg_start_q marks the first CONFIG cycle, during which configurator responses are ignored
  assign live      = state_q == CONFIG && !cfg_start;
  assign done      = live && cfg_done && !cfg_err;
  assign fail      = live && (cfg_err || (cnt_q == 24'd0 && !cfg_done));
  assign retry_inc = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == 24'd0) ? cnt_q : cnt_q - 24'd1;
    retry_d = retry_q;
    case (state_q)
      OFF: begin
        state_d = PWRUP;
        cnt_d   = LD_PWDN;
        retry_d = 2'd0;
      end
      PWRUP: if (cnt_q == 24'd0) begin
        state_d = RSTREL;
        cnt_d   = LD_RST;
      end
      RSTREL: if (cnt_q == 24'd0) begin
        state_d = CONFIG;
        cnt_d   = LD_CFG;
      end
      CONFIG: if (done) begin
        state_d = RUN;
      end else if (fail) begin
        retry_d = retry_inc;
        state_d = (retry_inc == MAXR) ? FAULT : PWRUP;
        cnt_d   = LD_PWDN;
      end
      RUN, FAULT: state_d = state_q;
      default: state_d = OFF;
    endcase
    if (!enable) begin
      state_d = OFF;
      cnt_d   = 24'd0;
      retry_d = (state_q == OFF || state_q == PWRUP || state_q == RSTREL || state_q == CONFIG ||
                 state_q == RUN || state_q == FAULT) ? retry_q : retry_q;
    end
  end
  // outputs decode the next state so they change on the same edge as the state register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= OFF;
      cnt_q        <= 24'd0;
      retry_q      <= 2'd0;
      mipi_pwdn_n  <= 1'b0;
      mipi_reset_n <= 1'b0;
      xclk_en      <= 1'b0;
      cfg_start    <= 1'b0;
      ready        <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      mipi_pwdn_n  <= state_d inside {PWRUP, RSTREL, CONFIG, RUN};
      mipi_reset_n <= state_d inside {RSTREL, CONFIG, RUN};
      xclk_en      <= state_d inside {PWRUP, RSTREL, CONFIG, RUN};
      cfg_start    <= state_d == CONFIG && state_q != CONFIG;
      ready        <= state_d == RUN;
      fault        <= state_d == FAULT;
    end
  end
  assign retry_cnt = retry_q;
  assign state     = state_q;
endmodule

// File: tb/tb_d8m_power_sequencer.sv
// tb_d8m_power_sequencer: directed and randomized checks of the power sequencer against a phase/elapsed-time model.
module tb_d8m_power_sequencer;
  localparam int TP = 8, TR = 4, TC = 16, MR = 2;
  logic clk_clk = 0, reset_reset_n = 0, enable = 0, cfg_done = 0, cfg_err = 0;
  logic mipi_pwdn_n, mipi_reset_n, xclk_en, cfg_start, ready, fault;
  logic [1:0] retry_cnt;
  logic [2:0] state;
  int checks = 0, failures = 0;
  int ph = 0, el = 0, rc = 0;

  d8m_power_sequencer #(.T_PWDN_CYC(TP), .T_RST_CYC(TR), .T_CFG_TO(TC), .MAX_RETRY(MR)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(enable), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .mipi_pwdn_n(mipi_pwdn_n), .mipi_reset_n(mipi_reset_n), .xclk_en(xclk_en),
    .cfg_start(cfg_start), .ready(ready), .fault(fault), .retry_cnt(retry_cnt), .state(state));

  always #5 clk_clk = ~clk_clk;

  // phase = state code, el = cycles already spent in the phase
  always @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ph = 0; el = 0; rc = 0;
    end else if (!enable) begin
      ph = 0; el = 0;
    end else begin
      case (ph)
        0: begin ph = 1; el = 0; rc = 0; end
        1: if (el + 1 == TP) begin ph = 2; el = 0; end else el++;
        2: if (el + 1 == TR) begin ph = 3; el = 0; end else el++;
        3: if (el > 0 && cfg_done && !cfg_err) begin
             ph = 4;
           end else if (el > 0 && (cfg_err || el + 1 >= TC)) begin
             rc = (rc < 3) ? rc + 1 : 3;
             ph = (rc == MR) ? 5 : 1;
             el = 0;
           end else el++;
        default: ;
      endcase
    end
  end

  function automatic logic [10:0] expected();
    logic on = ph >= 1 && ph <= 4;
    return {3'(ph), 2'(rc), on, ph >= 2 && ph <= 4, on, ph == 3 && el == 0, ph == 4, ph == 5};
  endfunction

  always @(negedge clk_clk) begin
    logic [10:0] got, exp;
    got = {state, retry_cnt, mipi_pwdn_n, mipi_reset_n, xclk_en, cfg_start, ready, fault};
    exp = expected();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL model t=%0t {state,retry,pwdn_n,reset_n,xclk,start,ready,fault} got=%b expected=%b", $time, got, exp);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic restart();
    enable = 0; tick(1);
    enable = 1; tick(1);
  endtask

  initial begin
    tick(3);
    chk("reset_state", int'(state), 0);
    chk("reset_outs", int'({mipi_pwdn_n, mipi_reset_n, xclk_en, cfg_start, ready, fault, retry_cnt}), 0);
    reset_reset_n = 1;
    tick(1);
    chk("off_hold", int'(state), 0);
    // nominal bring-up: enable raised just after edge 0
    enable = 1; tick(1);
    chk("nom_pwdn_e1", int'(mipi_pwdn_n), 1);
    chk("nom_rstn_e1", int'(mipi_reset_n), 0);
    tick(7);
    chk("nom_rstn_e8", int'(mipi_reset_n), 0);
    tick(1);
    chk("nom_rstn_e9", int'(mipi_reset_n), 1);
    tick(4);
    chk("nom_start_e13", int'(cfg_start), 1);
    tick(1);
    chk("nom_start_e14", int'(cfg_start), 0);
    tick(1);
    cfg_done = 1; tick(1); cfg_done = 0;
    chk("nom_ready_e16", int'(ready), 1);
    chk("nom_retry", int'(retry_cnt), 0);
    chk("model_nom_phase", ph, 4);
    // error retry
    restart(); tick(12);
    chk("err_config", int'(state), 3);
    tick(1);
    cfg_err = 1; tick(1); cfg_err = 0;
    chk("err_pwrup", int'(state), 1);
    chk("err_rstn_low", int'(mipi_reset_n), 0);
    chk("err_retry1", int'(retry_cnt), 1);
    tick(7);
    chk("err_rstn_low8", int'(mipi_reset_n), 0);
    tick(1);
    chk("err_rstn_back", int'(mipi_reset_n), 1);
    tick(4);
    chk("err_restart", int'(cfg_start), 1);
    tick(1);
    cfg_done = 1; tick(1); cfg_done = 0;
    chk("err_run", int'(ready), 1);
    chk("err_run_retry", int'(retry_cnt), 1);
    // two timeouts to FAULT
    restart(); tick(12);
    chk("to_config1", int'(state), 3);
    tick(16);
    chk("to_first", int'(state), 1);
    chk("model_to_rc", rc, 1);
    tick(12); tick(15);
    chk("to_config2", int'(state), 3);
    tick(1);
    chk("to_fault_state", int'(state), 5);
    chk("to_fault", int'(fault), 1);
    chk("to_fault_pwdn", int'(mipi_pwdn_n), 0);
    chk("to_fault_retry", int'(retry_cnt), 2);
    tick(5);
    chk("fault_hold", int'(state), 5);
    enable = 0; tick(1);
    chk("fault_off", int'(state), 0);
    // simultaneous done+err, then done on the exact timeout edge
    enable = 1; tick(1); tick(12); tick(1);
    cfg_done = 1; cfg_err = 1; tick(1); cfg_done = 0; cfg_err = 0;
    chk("sim_fail", int'(state), 1);
    chk("sim_retry", int'(retry_cnt), 1);
    tick(12); tick(15);
    cfg_done = 1; tick(1); cfg_done = 0;
    chk("to_edge_done", int'(state), 4);
    // done alongside cfg_start is ignored, timeout still runs
    restart(); tick(12);
    chk("ign_start", int'(cfg_start), 1);
    cfg_done = 1; tick(1); cfg_done = 0;
    chk("ign_done", int'(state), 3);
    tick(15);
    chk("ign_timeout", int'(state), 1);
    chk("ign_retry", int'(retry_cnt), 1);
    // abort mid-PWRUP
    restart(); tick(4);
    enable = 0; tick(1);
    chk("abort_state", int'(state), 0);
    chk("abort_outs", int'({mipi_pwdn_n, mipi_reset_n, xclk_en, cfg_start, ready, fault}), 0);
    // async reset in RUN with nonzero retry
    enable = 1; tick(1); tick(12); tick(1);
    cfg_err = 1; tick(1); cfg_err = 0;
    tick(12); tick(1);
    cfg_done = 1; tick(1); cfg_done = 0;
    chk("rr_run", int'(state), 4);
    chk("rr_retry", int'(retry_cnt), 1);
    reset_reset_n = 0; #2;
    chk("rr_async_state", int'(state), 0);
    chk("rr_async_outs", int'({mipi_pwdn_n, mipi_reset_n, xclk_en, ready, retry_cnt}), 0);
    tick(1);
    reset_reset_n = 1; tick(1);
    chk("rr_restart", int'(state), 1);
    chk("rr_retry0", int'(retry_cnt), 0);
    // randomized traffic
    for (int i = 0; i < 6000; i++) begin
      if (!enable) enable = $urandom_range(0, 9) == 0;
      else if ($urandom_range(0, 399) == 0) enable = 0;
      cfg_done = $urandom_range(0, 29) == 0;
      cfg_err = $urandom_range(0, 69) == 0;
      reset_reset_n = $urandom_range(0, 1499) != 0;
      tick(1);
    end
    reset_reset_n = 1; enable = 0; cfg_done = 0; cfg_err = 0;
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/d8m_power_sequencer.md
D8M_POWER_SEQUENCER -- requirements
Module: d8m_power_sequencer

Interface
REQ-001 The block SHALL have parameter T_PWDN_CYC, default 500000, PWRUP dwell in clk_clk cycles (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter T_RST_CYC, default 50000, RSTREL dwell in cycles.
REQ-003 The block SHALL have parameter T_CFG_TO, default 5000000, CONFIG timeout in cycles.
REQ-004 The block SHALL have parameter MAX_RETRY, default 3, allowed configuration failures before FAULT (range 1..3).
REQ-005 clk_clk  in  1  system clock; all logic is single-clock on its rising edge.
REQ-006 reset_reset_n  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  sequence request; high = power camera up, low = power down.
REQ-008 cfg_done  in  1  one-cycle pulse from the I2C configurator: register load complete.
REQ-009 cfg_err  in  1  one-cycle pulse from the I2C configurator: NACK or abort.
REQ-010 mipi_pwdn_n  out  1  MIPI bridge/sensor power-down, active-low.
REQ-011 mipi_reset_n  out  1  MIPI bridge/sensor reset, active-low.
REQ-012 xclk_en  out  1  enable for the d8m_xclkin_clk gate.
REQ-013 cfg_start  out  1  one-cycle pulse starting the I2C configurator.
REQ-014 ready  out  1  high only in RUN.
REQ-015 fault  out  1  high only in FAULT.
REQ-016 retry_cnt  out  2  configuration failures since last OFF.
REQ-017 state  out  3  current state encoding.

Function
REQ-018 States and encodings SHALL be: OFF=0, PWRUP=1, RSTREL=2, CONFIG=3, RUN=4, FAULT=5; codes 6-7 SHALL transition to OFF on the next edge.
REQ-019 Output decode SHALL be registered and follow state: OFF: all outputs 0; PWRUP: pwdn_n=1, reset_n=0, xclk_en=1; RSTREL/CONFIG/RUN: pwdn_n=1, reset_n=1, xclk_en=1; FAULT: pwdn_n=0, reset_n=0, xclk_en=0.
REQ-020 OFF SHALL go to PWRUP on the first edge with enable=1, loading the dwell counter and clearing retry_cnt.
REQ-021 PWRUP SHALL last exactly T_PWDN_CYC cycles, then go to RSTREL.
REQ-022 RSTREL SHALL last exactly T_RST_CYC cycles, then go to CONFIG.
REQ-023 cfg_start SHALL be high only during the first CONFIG cycle; cfg_done/cfg_err SHALL be ignored during that cycle.
REQ-024 From the second CONFIG cycle onward, cfg_done=1 with cfg_err=0 SHALL cause a transition to RUN.
REQ-025 A failure is cfg_err=1 in CONFIG or T_CFG_TO cycles elapsed after cfg_start with no cfg_done; cfg_err SHALL win over a simultaneous cfg_done, and cfg_done SHALL win over a timeout expiring on the same cycle.
REQ-026 On failure, retry_cnt SHALL increment; if the new value equals MAX_RETRY, the next state SHALL be FAULT; otherwise PWRUP, with reset re-asserted and the dwell counter reloaded.
REQ-027 retry_cnt SHALL saturate at 3 and SHALL clear only on the OFF->PWRUP transition and on reset.
REQ-028 RUN SHALL hold while enable=1 and SHALL ignore cfg_done/cfg_err.
REQ-029 FAULT SHALL hold while enable=1.
REQ-030 enable=0 in any state SHALL force OFF on the next edge, overriding every other transition, including mid-dwell and mid-CONFIG; any pending timeout is discarded.
REQ-031 Dwell/timeout counter SHALL be 24 bits wide, loaded on state entry and counting down; parameter values above 2^24-1 SHALL be rejected at elaboration.

Reset
REQ-032 While reset_reset_n=0, the block SHALL be in OFF with all outputs 0, retry_cnt=0 and counter=0, asynchronously.
REQ-033 After deassertion, the block SHALL need an enable edge sampled high to leave OFF; enable already high SHALL start PWRUP on the first edge.

Verification (T_PWDN_CYC=8, T_RST_CYC=4, T_CFG_TO=16, MAX_RETRY=2)
REQ-034 Nominal: enable=1 at edge 0. Required: pwdn_n=1 at edge 1; reset_n=1 at edge 9; cfg_start pulse at edge 13; cfg_done at edge 15; ready=1 at edge 16 with retry_cnt=0.
REQ-035 Error retry: cfg_err on the first CONFIG pass, then cfg_done on the second. Required: reset_n drops for 8 cycles; a second cfg_start occurs 12 cycles after the error; RUN is reached with retry_cnt=1.
REQ-036 Timeout to FAULT: no cfg_done/cfg_err. Required: two timeouts of 16 cycles each, then state=5, fault=1, pwdn_n=0, retry_cnt=2; enable=0 then gives OFF at the next edge.
REQ-037 Simultaneous inputs: cfg_done and cfg_err both high in the same CONFIG cycle. Required: treated as a failure, with retry_cnt incremented. Separately: cfg_done on the exact timeout cycle goes to RUN.
REQ-038 Abort and reset: enable=0 at the 5th PWRUP cycle gives OFF with all outputs 0 at the next edge. reset_reset_n pulsed low in RUN gives immediate OFF; re-enable restarts from PWRUP with retry_cnt=0.
REQ-039 cfg_start at the same edge as cfg_done: cfg_done ignored, the block stays in CONFIG, and the timeout counter runs.
